ahb_bus_arbiter: RTL and testbench
==================================

// Module: ahb_bus_arbiter
// PURPOSE
//   Round-robin AHB bus arbiter that shares the slave-side bus (register-file slaves, decoder) between
//   NUM_MASTERS requesters. Issues one-hot HGRANT, tracks address-phase owner (HMASTER) and data-phase
//   owner (HMASTER_DATA) for the address/control and write-data muxes, and holds ownership across
//   fixed-length bursts and locked sequences. Sits between master request lines and the bus muxes.
// PARAMETERS
//   NUM_MASTERS     4  number of requesting masters (2..16)
//   MASTER_ID_WIDTH 2  width of master index, >= clog2(NUM_MASTERS)
//   DEFAULT_MASTER  0  master parked on the bus when nobody requests
// PORTS
//   HCLK          in   1                bus clock, all state on rising edge
//   HRESETn       in   1                asynchronous, active-low reset
//   HBUSREQ       in   NUM_MASTERS      bus request per master, bit i = master i
//   HLOCK         in   NUM_MASTERS      locked-transfer request per master
//   HTRANS        in   2                muxed HTRANS of current address-phase owner
//   HBURST        in   3                muxed HBURST of current address-phase owner
//   HREADY        in   1                bus-wide ready (selected slave HREADYOUT)
//   HGRANT        out  NUM_MASTERS      registered one-hot grant
//   HMASTER       out  MASTER_ID_WIDTH  address-phase owner index (drives addr/control mux)
//   HMASTER_DATA  out  MASTER_ID_WIDTH  data-phase owner index (drives HWDATA mux, HRDATA routing)
//   HMASTLOCK     out  1                current address phase is part of a locked sequence
// BEHAVIOUR
//   Reset (async, immediate, also mid-burst): HGRANT=one-hot DEFAULT_MASTER; HMASTER=HMASTER_DATA=
//     DEFAULT_MASTER; HMASTLOCK=0; rr_ptr=DEFAULT_MASTER; beats_left=0; state=ARB.
//   Transfer accepted = HREADY=1 at the edge. HTRANS: IDLE=00 BUSY=01 NONSEQ=10 SEQ=11.
//   Pipeline: HGRANT registered -> HMASTER<=index(HGRANT) on edge with HREADY=1 ->
//     HMASTER_DATA<=HMASTER on edge with HREADY=1. HREADY=0 freezes HMASTER, HMASTER_DATA, HMASTLOCK.
//   Winner: first requesting master scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_MASTERS); no request ->
//     DEFAULT_MASTER. On every HGRANT update rr_ptr<=winner index.
//   HGRANT updates only on an edge where HREADY=1 and state=ARB, or on the burst/lock release edge below.
//   FSM states:
//     ARB:    rearbitrate each accepted cycle. Accepted NONSEQ with HBURST=INCR4/WRAP4, INCR8/WRAP8,
//             INCR16/WRAP16 -> beats_left=3/7/15, go BURST, grant held. Owner HLOCK=1 with accepted
//             NONSEQ -> LOCKED. SINGLE/INCR(undefined) stay in ARB (may be cut at any beat).
//     BURST:  accepted SEQ -> beats_left-1; BUSY or HREADY=0 -> hold. Accepted SEQ with beats_left=1 ->
//             rearbitrate on that edge, go ARB. Accepted IDLE/NONSEQ (early termination) -> ARB, beats_left=0.
//     LOCKED: grant held while owner HLOCK=1; first accepted cycle with owner HLOCK=0 -> rearbitrate, ARB.
//   HMASTLOCK <= HLOCK[index(HGRANT)] on the edge HMASTER loads; stays set through the locked last beat.
//   Handover after burst: old owner keeps HMASTER one more accepted cycle (drives IDLE), then new owner.
//   Simultaneous: locked burst -> LOCKED has priority over BURST count; granted master dropping HBUSREQ
//     in ARB loses grant on next accepted edge; all requests dropped -> park on DEFAULT_MASTER.
//   Grant is never zero-hot and never multi-hot; HMASTER always < NUM_MASTERS.
// TESTING
//   Reset: hold HRESETn=0 mid-burst with HBUSREQ=4'b1111 -> HGRANT=0001, HMASTER=0, HMASTLOCK=0 at once.
//   RR fairness: HBUSREQ=1111, SINGLE NONSEQs, HREADY=1 -> grants cycle 0010,0100,1000,0001,...
//   INCR4 hold: M2 NONSEQ INCR4 + 3 SEQ, M1 requesting -> HGRANT=0100 until 3rd SEQ accepted, then 0010.
//   Wait/BUSY: INCR4 with HREADY=0 2 cycles and one BUSY -> beats_left frozen, grant held, HMASTER stable.
//   Lock: M3 HLOCK=1 for 3 SINGLE transfers, M0 requesting -> HGRANT=1000, HMASTLOCK=1 throughout, then M0.
//   Park/data: HBUSREQ=0 -> HGRANT=DEFAULT_MASTER; HMASTER_DATA equals prior HMASTER one accepted cycle later.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter with burst/lock hold and address/data-phase owner tracking.
// Bursts and locks are attributed to the currently granted master (rr_ptr always equals index(HGRANT)).
module ahb_bus_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int MASTER_ID_WIDTH = 2,
  parameter int DEFAULT_MASTER  = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [NUM_MASTERS-1:0]     HBUSREQ,
  input  logic [NUM_MASTERS-1:0]     HLOCK,
  input  logic [1:0]                 HTRANS,
  input  logic [2:0]                 HBURST,
  input  logic                       HREADY,
  output logic [NUM_MASTERS-1:0]     HGRANT,
  output logic [MASTER_ID_WIDTH-1:0] HMASTER,
  output logic [MASTER_ID_WIDTH-1:0] HMASTER_DATA,
  output logic                       HMASTLOCK
);
  typedef enum logic [1:0] {ARB, BURST, LOCKED} state_t;
  localparam logic [MASTER_ID_WIDTH-1:0] DEF = MASTER_ID_WIDTH'(DEFAULT_MASTER);
  localparam logic [1:0] T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  state_t state, state_nx;
  logic [MASTER_ID_WIDTH-1:0] rr_ptr, winner, cand;
  logic [3:0] beats_left, beats_nx, burst_len;
  logic rearb, owner_lock, nonseq;
  assign owner_lock = HLOCK[rr_ptr];
  assign nonseq = HTRANS == T_NONSEQ;
  assign burst_len = HBURST >= 3'd6 ? 4'd15 : HBURST >= 3'd4 ? 4'd7 : HBURST >= 3'd2 ? 4'd3 : 4'd0;
  // descending scan: the last hit is the nearest requester after rr_ptr
  always_comb begin
    winner = DEF;
    cand = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = MASTER_ID_WIDTH'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (HBUSREQ[cand]) winner = cand;
    end
  end
  always_comb begin
    state_nx = state;
    beats_nx = beats_left;
    rearb = 1'b0;
    if (HREADY)
      case (state)
        ARB:
          if (nonseq && owner_lock) state_nx = LOCKED;
          else if (nonseq && burst_len != 4'd0) begin
            state_nx = BURST;
            beats_nx = burst_len;
          end else rearb = 1'b1;
        BURST:
          if (HTRANS == T_SEQ) begin
            beats_nx = beats_left - 4'd1;
            if (beats_left == 4'd1) begin
              rearb = 1'b1;
              state_nx = ARB;
            end
          end else if (HTRANS != T_BUSY) begin
            state_nx = ARB;
            beats_nx = 4'd0;
          end
        LOCKED:
          if (!owner_lock) begin
            rearb = 1'b1;
            state_nx = ARB;
          end
        default: state_nx = ARB;
      endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= ARB;
      beats_left <= 4'd0;
      rr_ptr <= DEF;
      HGRANT <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      HMASTER <= DEF;
      HMASTER_DATA <= DEF;
      HMASTLOCK <= 1'b0;
    end else begin
      state <= state_nx;
      beats_left <= beats_nx;
      if (rearb) begin
        rr_ptr <= winner;
        HGRANT <= NUM_MASTERS'(1) << winner;
      end
      if (HREADY) begin
        HMASTER <= rr_ptr;
        HMASTER_DATA <= HMASTER;
        HMASTLOCK <= owner_lock;
      end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: table-driven directed vectors for the round-robin AHB arbiter,
// plus a hand-written async-reset-mid-burst sequence.
module tb_ahb_bus_arbiter;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR16 = 3'd7;
  typedef struct {
    logic [3:0] req;
    logic [3:0] lck;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] d;
    logic       ml;
  } vec_t;
  logic HCLK = 1'b0;
  logic HRESETn;
  logic [3:0] HBUSREQ = '0, HLOCK = '0, HGRANT;
  logic [1:0] HTRANS = IDLE, HMASTER, HMASTER_DATA;
  logic [2:0] HBURST = SINGLE;
  logic HREADY = 1'b1, HMASTLOCK;
  int vectors = 0, miscompares = 0;
  vec_t tv[$];
  ahb_bus_arbiter #(.NUM_MASTERS(4), .MASTER_ID_WIDTH(2), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HTRANS(HTRANS),
    .HBURST(HBURST), .HREADY(HREADY), .HGRANT(HGRANT), .HMASTER(HMASTER),
    .HMASTER_DATA(HMASTER_DATA), .HMASTLOCK(HMASTLOCK)
  );
  always #5 HCLK = ~HCLK;
  function automatic vec_t v(logic [3:0] req, logic [3:0] lck, logic [1:0] tr, logic [2:0] bu,
                             logic rdy, logic [3:0] g, logic [1:0] m, logic [1:0] d, logic ml);
    vec_t t;
    t.req = req; t.lck = lck; t.tr = tr; t.bu = bu; t.rdy = rdy;
    t.g = g; t.m = m; t.d = d; t.ml = ml;
    return t;
  endfunction
  task automatic check(input string name, input logic [3:0] g, input logic [1:0] m,
                       input logic [1:0] d, input logic ml);
    vectors++;
    if (HGRANT !== g || HMASTER !== m || HMASTER_DATA !== d || HMASTLOCK !== ml) begin
      miscompares++;
      $display("FAIL %s: got grant=%b master=%0d data=%0d mlock=%b, want grant=%b master=%0d data=%0d mlock=%b",
               name, HGRANT, HMASTER, HMASTER_DATA, HMASTLOCK, g, m, d, ml);
    end
  endtask
  task automatic apply(input vec_t t, input string name);
    HBUSREQ = t.req; HLOCK = t.lck; HTRANS = t.tr; HBURST = t.bu; HREADY = t.rdy;
    @(posedge HCLK);
    #1;
    check(name, t.g, t.m, t.d, t.ml);
  endtask
  initial begin
    // round-robin fairness, then an HREADY=0 freeze
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 1, 4'b0010, 0, 0, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 1, 4'b0100, 1, 0, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 1, 4'b1000, 2, 1, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 1, 4'b0001, 3, 2, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 1, 4'b0010, 0, 3, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, SINGLE, 0, 4'b0010, 0, 3, 0));
    // INCR4 by M2 with M1 waiting
    tv.push_back(v(4'h6, 4'h0, IDLE, SINGLE, 1, 4'b0100, 1, 0, 0));
    tv.push_back(v(4'h6, 4'h0, NSEQ, INCR4,  1, 4'b0100, 2, 1, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0010, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, IDLE, SINGLE, 1, 4'b0100, 1, 2, 0));
    // INCR4 with two wait states and a BUSY beat
    tv.push_back(v(4'h6, 4'h0, NSEQ, INCR4,  1, 4'b0100, 2, 1, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  0, 4'b0100, 2, 1, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  0, 4'b0100, 2, 1, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, BUSY, INCR4,  1, 4'b0100, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0100, 2, 2, 0));
    tv.push_back(v(4'h6, 4'h0, SEQ,  INCR4,  1, 4'b0010, 2, 2, 0));
    // M3 locked for three singles while M0 requests
    tv.push_back(v(4'h9, 4'h8, IDLE, SINGLE, 1, 4'b1000, 1, 2, 0));
    tv.push_back(v(4'h9, 4'h8, NSEQ, SINGLE, 1, 4'b1000, 3, 1, 1));
    tv.push_back(v(4'h9, 4'h8, NSEQ, SINGLE, 1, 4'b1000, 3, 3, 1));
    tv.push_back(v(4'h9, 4'h8, NSEQ, SINGLE, 1, 4'b1000, 3, 3, 1));
    tv.push_back(v(4'h9, 4'h0, IDLE, SINGLE, 1, 4'b0001, 3, 3, 0));
    tv.push_back(v(4'h9, 4'h0, IDLE, SINGLE, 1, 4'b1000, 0, 3, 0));
    // park on default master, data-phase owner trails by one accepted cycle
    tv.push_back(v(4'h0, 4'h0, IDLE, SINGLE, 1, 4'b0001, 3, 0, 0));
    tv.push_back(v(4'h0, 4'h0, IDLE, SINGLE, 1, 4'b0001, 0, 3, 0));
    tv.push_back(v(4'h0, 4'h0, IDLE, SINGLE, 1, 4'b0001, 0, 0, 0));
    // undefined-length INCR does not hold the grant
    tv.push_back(v(4'h3, 4'h0, NSEQ, INCR,   1, 4'b0010, 0, 0, 0));
    tv.push_back(v(4'h3, 4'h0, SEQ,  INCR,   1, 4'b0001, 1, 0, 0));
    // start an INCR16 on M2 that the reset below interrupts
    tv.push_back(v(4'hF, 4'h0, IDLE, SINGLE, 1, 4'b0010, 0, 1, 0));
    tv.push_back(v(4'hF, 4'h0, IDLE, SINGLE, 1, 4'b0100, 1, 0, 0));
    tv.push_back(v(4'hF, 4'h0, NSEQ, INCR16, 1, 4'b0100, 2, 1, 0));
    tv.push_back(v(4'hF, 4'h0, SEQ,  INCR16, 1, 4'b0100, 2, 2, 0));
    HRESETn = 1'b1;
    #1 HRESETn = 1'b0;
    #2 check("reset_state", 4'b0001, 0, 0, 0);
    @(posedge HCLK);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));
    // asynchronous reset mid-burst, between clock edges
    #2 HRESETn = 1'b0;
    #1 check("async_reset_mid_burst", 4'b0001, 0, 0, 0);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    apply(v(4'hF, 4'h0, SEQ, INCR16, 1, 4'b0010, 0, 0, 0), "post_reset_rearb");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
